ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Sequencing controller for the two-digit seven-segment display fed by the keypad decoder.
- Captures keypad digits calculator-style: each new digit enters on the right and the previous right digit moves to the left.
- Time-multiplexes the shared `disp_ctrl` decoder and `chip_sel` line across both digits, with a blanking gap between digits to prevent ghosting.
- Single-digit mode holds one digit, chosen by a debounced button pulse.
- Sits between the debounce/single-pulse stage and the `disp_ctrl` → `seg` path.

Parameters:
- `CLK_FREQ`, 125_000_000, input clock frequency in Hz.
- `REFRESH_HZ`, 1000, full left+right scan rate in Hz. DWELL = CLK_FREQ/(2*REFRESH_HZ) cycles per digit.
- `BLANK_CYCLES`, 64, blanking cycles inserted at each digit switch. Must satisfy 1 ≤ BLANK_CYCLES < DWELL; elaboration error otherwise.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `key_valid`  in  1  single-cycle pulse: a new key has been decoded
- `key_code`  in  4  keypad digit, valid when `key_valid`=1
- `clear`  in  1  single-cycle pulse: zero both digits
- `mode_dual`  in  1  1 = two-digit scan, 0 = single-digit hold
- `toggle`  in  1  single-cycle pulse: flip the selected digit in single mode
- `digit_l`  out  4  stored left digit
- `digit_r`  out  4  stored right digit
- `entry_cnt`  out  2  digits entered since reset/clear, saturates at 2
- `disp_val`  out  4  value to `disp_ctrl`
- `blank`  out  1  1 = segments must be forced off
- `chip_sel`  out  1  1 = left digit, 0 = right digit

Behaviour:
- All outputs are registered.
- Reset values: `digit_l`=0, `digit_r`=0, `entry_cnt`=0, `disp_val`=0, `blank`=1, `chip_sel`=0, `sel`=0, `state`=BLANK_RL, timer=0.

Digit entry:
- On `key_valid` at edge n: `digit_l`←`digit_r` and `digit_r`←`key_code`, visible after edge n. `entry_cnt` increments, saturating at 2.
- `clear` sets `digit_l`, `digit_r` and `entry_cnt` to 0.
- `clear` and `key_valid` in the same cycle: `clear` wins and the key is dropped.
- `key_valid` is honoured in both modes.

Dual-mode scan FSM (`mode_dual`=1):
- States: SHOW_L → BLANK_LR → SHOW_R → BLANK_RL → SHOW_L.
- SHOW_* lasts DWELL cycles; BLANK_* lasts BLANK_CYCLES cycles.
- The timer resets to 0 on every state entry. The last cycle of a state is timer = duration−1; the state advances on the next edge.
- Registered outputs follow the state one cycle later:
  - SHOW_L: `chip_sel`=1, `disp_val`=`digit_l`, `blank`=0.
  - SHOW_R: `chip_sel`=0, `disp_val`=`digit_r`, `blank`=0.
  - BLANK_*: `blank`=1, `chip_sel` holds the previous value, `disp_val` holds.
- The full period is 2*(DWELL+BLANK_CYCLES) cycles.
- Digit updates during SHOW_* appear on `disp_val` within 1 cycle, with no wait for the next scan.

Single mode (`mode_dual`=0):
- FSM forced to BLANK_RL with the timer held at 0.
- `toggle` flips `sel`.
- Outputs: `chip_sel`=`sel`, `disp_val`=`digit_r`, `blank`=0.

Mode changes:
- 1→0: takes effect on the next edge. The scan is abandoned mid-state.
- 0→1: the FSM starts in BLANK_RL with the timer at 0, so the first lit digit is always the left one, after BLANK_CYCLES.
- `toggle` is ignored in dual mode; `sel` is retained.
- Reset deassertion mid-operation: no state survives. After reset, the FSM starts in BLANK_RL.

Decomposition:
- Package `ssd_pkg`:
  - `typedef enum logic [1:0] {SHOW_L, BLANK_LR, SHOW_R, BLANK_RL} scan_state_t`
  - `localparam DIGIT_W = 4`
  - `localparam logic CSEL_LEFT = 1'b1`
- Sub-module `dwell_timer`:
  - Parameter `MAX`; inputs `restart` and `len`; output `done`.
  - Down/up counter, width $clog2(DWELL).
  - Instantiated once and shared by SHOW and BLANK states.

Test Plan:
All scenarios use CLK_FREQ=1000, REFRESH_HZ=50 (DWELL=10), BLANK_CYCLES=2.
1. Reset asserted, then released with `mode_dual`=1 → `blank`=1 for 2 cycles. Then `chip_sel`=1 and `disp_val`=0 for 10 cycles, 2 blank, `chip_sel`=0 for 10; the period measures 24 cycles.
2. `key_valid` with code 3, then with code 7 → `digit_l`=3, `digit_r`=7, `entry_cnt`=2. A third key 9 → `digit_l`=7, `digit_r`=9, `entry_cnt` stays 2.
3. `clear` and `key_valid` (code 5) in the same cycle, with prior digits 7/9 → `digit_l`=0, `digit_r`=0, `entry_cnt`=0.
4. `mode_dual`=0 with `digit_r`=4, then `toggle` twice → `blank`=0 and `disp_val`=4 throughout. `chip_sel` goes 0→1→0, each change one cycle after the pulse.
5. Switch 0→1 mid-operation, then 1→0 during SHOW_R → on 0→1, two blank cycles precede SHOW_L. On 1→0, the next cycle has `blank`=0 and `chip_sel`=`sel`.
6. Assert `rst` during SHOW_R → `blank`=1 immediately (asynchronously), both digits 0, and the scan restarts with BLANK_RL after release.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    typedef enum logic [1:0] {SHOW_L, BLANK_LR, SHOW_R, BLANK_RL} scan_state_t;

    localparam int   DIGIT_W   = 4;
    localparam logic CSEL_LEFT = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Up-counting dwell timer shared by all scan states; done flags the last cycle
// of a state whose duration is len cycles.
module dwell_timer #(
    parameter int MAX = 10,
    localparam int W  = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W:0]   len,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = restart ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = ({1'b0, cnt_q} == (len - (W + 1)'(1)));

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Two-digit seven-segment controller: calculator-style digit capture and
// left/right time-multiplexing with a blanking gap at every digit switch.
//
// state    | meaning
// SHOW_L   | left digit lit, chip_sel = left
// BLANK_LR | segments off while switching left -> right
// SHOW_R   | right digit lit, chip_sel = right
// BLANK_RL | segments off while switching right -> left; parked here in single mode
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               clear,
    input  logic               mode_dual,
    input  logic               toggle,
    output logic [DIGIT_W-1:0] digit_l,
    output logic [DIGIT_W-1:0] digit_r,
    output logic [1:0]         entry_cnt,
    output logic [DIGIT_W-1:0] disp_val,
    output logic               blank,
    output logic               chip_sel
);

    localparam int DWELL = CLK_FREQ / (2 * REFRESH_HZ);
    localparam int TW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TW:0] SHOW_LEN  = (TW + 1)'(DWELL);
    localparam logic [TW:0] BLANK_LEN = (TW + 1)'(BLANK_CYCLES);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL) begin : g_bad_blank
        $error("ssd_scan_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DWELL");
    end

    scan_state_t        state_q, state_d;
    logic               sel_q, sel_d;
    logic [DIGIT_W-1:0] digit_l_q, digit_l_d, digit_r_q, digit_r_d;
    logic [1:0]         entry_cnt_q, entry_cnt_d;
    logic [DIGIT_W-1:0] disp_val_q, disp_val_d;
    logic               blank_q, blank_d;
    logic               chip_sel_q, chip_sel_d;
    logic               tmr_restart, tmr_done;
    logic [TW:0]        tmr_len;

    dwell_timer #(.MAX(DWELL)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (tmr_restart),
        .len     (tmr_len),
        .done    (tmr_done)
    );

    // clear beats a simultaneous key
    always_comb begin
        digit_l_d   = digit_l_q;
        digit_r_d   = digit_r_q;
        entry_cnt_d = entry_cnt_q;
        if (clear) begin
            digit_l_d   = '0;
            digit_r_d   = '0;
            entry_cnt_d = '0;
        end else if (key_valid) begin
            digit_l_d = digit_r_q;
            digit_r_d = key_code;
            if (entry_cnt_q != 2'd2) begin
                entry_cnt_d = entry_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_len     = (state_q == SHOW_L || state_q == SHOW_R) ? SHOW_LEN : BLANK_LEN;
        tmr_restart = !mode_dual || tmr_done;
        sel_d       = sel_q ^ (toggle & ~mode_dual);
        if (!mode_dual) begin
            state_d = BLANK_RL;
        end else if (tmr_done) begin
            case (state_q)
                SHOW_L:   state_d = BLANK_LR;
                BLANK_LR: state_d = SHOW_R;
                SHOW_R:   state_d = BLANK_RL;
                BLANK_RL: state_d = SHOW_L;
                default:  state_d = BLANK_RL;
            endcase
        end
    end

    // Blanking states keep chip_sel and disp_val where they were.
    always_comb begin
        blank_d    = 1'b1;
        chip_sel_d = chip_sel_q;
        disp_val_d = disp_val_q;
        if (!mode_dual) begin
            blank_d    = 1'b0;
            chip_sel_d = sel_d;
            disp_val_d = digit_r_q;
        end else begin
            case (state_q)
                SHOW_L: begin
                    blank_d    = 1'b0;
                    chip_sel_d = CSEL_LEFT;
                    disp_val_d = digit_l_q;
                end
                SHOW_R: begin
                    blank_d    = 1'b0;
                    chip_sel_d = ~CSEL_LEFT;
                    disp_val_d = digit_r_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BLANK_RL;
            sel_q       <= 1'b0;
            digit_l_q   <= '0;
            digit_r_q   <= '0;
            entry_cnt_q <= '0;
            disp_val_q  <= '0;
            blank_q     <= 1'b1;
            chip_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            digit_l_q   <= digit_l_d;
            digit_r_q   <= digit_r_d;
            entry_cnt_q <= entry_cnt_d;
            disp_val_q  <= disp_val_d;
            blank_q     <= blank_d;
            chip_sel_q  <= chip_sel_d;
        end
    end

    assign digit_l   = digit_l_q;
    assign digit_r   = digit_r_q;
    assign entry_cnt = entry_cnt_q;
    assign disp_val  = disp_val_q;
    assign blank     = blank_q;
    assign chip_sel  = chip_sel_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with DWELL=10, BLANK_CYCLES=2 (24-cycle scan period).
module tb_ssd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, clear, mode_dual, toggle;
    logic [3:0] key_code;
    logic [3:0] digit_l, digit_r, disp_val;
    logic [1:0] entry_cnt;
    logic       blank, chip_sel;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .CLK_FREQ     (1000),
        .REFRESH_HZ   (50),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .clear     (clear),
        .mode_dual (mode_dual),
        .toggle    (toggle),
        .digit_l   (digit_l),
        .digit_r   (digit_r),
        .entry_cnt (entry_cnt),
        .disp_val  (disp_val),
        .blank     (blank),
        .chip_sel  (chip_sel)
    );

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic       clr;
        logic [3:0] exp_l;
        logic [3:0] exp_r;
        logic [1:0] exp_cnt;
    } entry_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scan model: first two edges are the lead-in blank, then a 24-cycle
    // period of left(10) / blank(2) / right(10) / blank(2).
    task automatic check_scan(input int n, input logic cs_init, input logic [3:0] dv_init,
                              input logic [3:0] l, input logic [3:0] r);
        logic       eb, ecs;
        logic [3:0] edv;
        int         m;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 5) toggle = 1'b1;
            if (k == 6) toggle = 1'b0;
            if (k <= 2) begin
                eb = 1'b1; ecs = cs_init; edv = dv_init;
            end else begin
                m = (k - 3) % 24;
                if (m < 10)      begin eb = 1'b0; ecs = 1'b1; edv = l; end
                else if (m < 12) begin eb = 1'b1; ecs = 1'b1; edv = l; end
                else if (m < 22) begin eb = 1'b0; ecs = 1'b0; edv = r; end
                else             begin eb = 1'b1; ecs = 1'b0; edv = r; end
            end
            chk("scan_blank", int'(blank), int'(eb));
            chk("scan_chip_sel", int'(chip_sel), int'(ecs));
            chk("scan_disp_val", int'(disp_val), int'(edv));
        end
    endtask

    entry_vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 4'd3, 1'b0, 4'd0, 4'd3, 2'd1};
        vecs[1] = '{1'b1, 4'd7, 1'b0, 4'd3, 4'd7, 2'd2};
        vecs[2] = '{1'b1, 4'd9, 1'b0, 4'd7, 4'd9, 2'd2};
        vecs[3] = '{1'b0, 4'd1, 1'b0, 4'd7, 4'd9, 2'd2};
        vecs[4] = '{1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 2'd0};
        vecs[5] = '{1'b1, 4'd4, 1'b0, 4'd0, 4'd4, 2'd1};
        vecs[6] = '{1'b0, 4'd6, 1'b1, 4'd0, 4'd0, 2'd0};
        vecs[7] = '{1'b1, 4'd8, 1'b0, 4'd0, 4'd8, 2'd1};
        vecs[8] = '{1'b1, 4'd4, 1'b0, 4'd8, 4'd4, 2'd2};

        rst = 1'b0; key_valid = 1'b0; key_code = 4'd0; clear = 1'b0;
        mode_dual = 1'b1; toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_blank", int'(blank), 1);
        chk("rst_chip_sel", int'(chip_sel), 0);
        chk("rst_disp_val", int'(disp_val), 0);
        chk("rst_digit_l", int'(digit_l), 0);
        chk("rst_digit_r", int'(digit_r), 0);
        chk("rst_entry_cnt", int'(entry_cnt), 0);
        rst = 1'b1;

        check_scan(60, 1'b0, 4'd0, 4'd0, 4'd0);

        foreach (vecs[i]) begin
            key_valid = vecs[i].kv;
            key_code  = vecs[i].code;
            clear     = vecs[i].clr;
            tick();
            key_valid = 1'b0;
            clear     = 1'b0;
            chk($sformatf("entry%0d_digit_l", i), int'(digit_l), int'(vecs[i].exp_l));
            chk($sformatf("entry%0d_digit_r", i), int'(digit_r), int'(vecs[i].exp_r));
            chk($sformatf("entry%0d_cnt", i), int'(entry_cnt), int'(vecs[i].exp_cnt));
        end

        // Single mode: chip_sel follows sel on the edge that samples toggle.
        mode_dual = 1'b0;
        tick();
        chk("single_blank", int'(blank), 0);
        chk("single_disp_val", int'(disp_val), 4);
        chk("single_chip_sel0", int'(chip_sel), 0);
        toggle = 1'b1; tick(); toggle = 1'b0;
        chk("toggle1_chip_sel", int'(chip_sel), 1);
        chk("toggle1_blank", int'(blank), 0);
        chk("toggle1_disp_val", int'(disp_val), 4);
        tick();
        chk("toggle1_hold", int'(chip_sel), 1);
        toggle = 1'b1; tick(); toggle = 1'b0;
        chk("toggle2_chip_sel", int'(chip_sel), 0);
        chk("toggle2_disp_val", int'(disp_val), 4);
        toggle = 1'b1; tick(); toggle = 1'b0;
        chk("toggle3_chip_sel", int'(chip_sel), 1);

        // 0->1: two blank cycles then left; toggle pulse inside the scan is ignored.
        mode_dual = 1'b1;
        check_scan(20, 1'b1, 4'd4, 4'd8, 4'd4);

        // 1->0 during SHOW_R: single outputs on the very next edge, sel still 1.
        mode_dual = 1'b0;
        tick();
        chk("abandon_blank", int'(blank), 0);
        chk("abandon_chip_sel", int'(chip_sel), 1);
        chk("abandon_disp_val", int'(disp_val), 4);

        mode_dual = 1'b1;
        check_scan(18, 1'b1, 4'd4, 4'd8, 4'd4);

        // Asynchronous reset in the middle of SHOW_R.
        rst = 1'b0;
        #2;
        chk("async_blank", int'(blank), 1);
        chk("async_digit_l", int'(digit_l), 0);
        chk("async_digit_r", int'(digit_r), 0);
        chk("async_entry_cnt", int'(entry_cnt), 0);
        chk("async_chip_sel", int'(chip_sel), 0);
        chk("async_disp_val", int'(disp_val), 0);
        rst = 1'b1;
        check_scan(30, 1'b0, 4'd0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
